// File: rtl/quad_adc_serializer_emu_if.sv
// AXI-Stream sample channel into the quad ADC serializer emulator.
// One beat carries all four channel samples in 16-bit fields.
interface quad_adc_serializer_emu_if #(
    parameter int DATA_W = 64
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/quad_adc_serializer_emu.sv
// Quad 2-lane serial ADC emulator: serializes 4-channel AXI-Stream samples MSB-first
// onto A/B lane pairs alongside a frame clock and an edge-aligned DDR bit clock.
module quad_adc_serializer_emu #(
    parameter int SAMPLE_BITS          = 14,
    parameter int FRAME_SLOTS          = 8,
    parameter int C_S_AXIS_TDATA_WIDTH = 64
) (
    input  logic                     s00_axis_aclk,
    input  logic                     s00_axis_areset,
    input  logic                     enable,
    quad_adc_serializer_emu_if.slave s00_axis,
    output logic                     FRAME_CLK,
    output logic                     DATA_CLK,
    output logic                     CH_1_A,
    output logic                     CH_1_B,
    output logic                     CH_2_A,
    output logic                     CH_2_B,
    output logic                     CH_3_A,
    output logic                     CH_3_B,
    output logic                     CH_4_A,
    output logic                     CH_4_B,
    output logic                     underrun,
    output logic [15:0]              frame_count
);
    localparam int SLOT_W = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);
    localparam logic [SLOT_W-1:0] HALF_SLOT = SLOT_W'(FRAME_SLOTS / 2);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;
    typedef logic [3:0][SAMPLE_BITS-1:0] quad_t;

    if ((SAMPLE_BITS % 2 != 0) || (SAMPLE_BITS < 2) || (SAMPLE_BITS > 16) ||
        (FRAME_SLOTS < SAMPLE_BITS / 2 + 1) || (FRAME_SLOTS % 2 != 0) ||
        (C_S_AXIS_TDATA_WIDTH != 64)) begin : g_bad_params
        $error("quad_adc_serializer_emu: unsupported SAMPLE_BITS/FRAME_SLOTS/TDATA width");
    end

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    quad_t             hold_q, hold_d;
    quad_t             shift_q, shift_d, shift_src;
    logic              hold_full_q, hold_full_d;
    logic [3:0]        lane_a_q, lane_a_d;
    logic [3:0]        lane_b_q, lane_b_d;
    logic              frame_clk_q, frame_clk_d;
    logic              data_clk_q, data_clk_d;
    logic              underrun_q, underrun_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              load_now;
    logic              produce;
    logic              tready;
    logic              accept;
    logic              unused_axis_bits;

    assign tready          = !s00_axis_areset && (!hold_full_q || load_now);
    assign s00_axis.tready = tready;
    assign accept          = s00_axis.tvalid && tready;
    assign unused_axis_bits = ^{s00_axis.tlast, s00_axis.tdata};

    // Frame engine: decides which slot (if any) the output registers show next.
    // NOTE: every variable in this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shift_src   = shift_q;
        shift_d     = shift_q;
        lane_a_d    = '0;
        lane_b_d    = '0;
        frame_clk_d = 1'b0;
        data_clk_d  = data_clk_q;
        frame_cnt_d = frame_cnt_q;
        underrun_d  = underrun_q;
        load_now    = 1'b0;
        produce     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_RUN;
                    load_now = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (slot_q == LAST_SLOT) begin
                    if (enable) begin
                        state_d  = ST_RUN;
                        load_now = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = enable ? ST_RUN : ST_DRAIN;
                    slot_d  = slot_q + SLOT_W'(1);
                    produce = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_now) begin
            produce     = 1'b1;
            slot_d      = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (hold_full_q) begin
                shift_src = hold_q;
            end else begin
                shift_src  = '0;
                underrun_d = 1'b1;
            end
        end

        // The top bit pair of the shifter is the current slot; it empties to zero
        // after SAMPLE_BITS/2 slots, which yields the all-zero padding slots.
        if (produce) begin
            for (int n = 0; n < 4; n++) begin
                lane_a_d[n] = shift_src[n][SAMPLE_BITS-1];
                lane_b_d[n] = shift_src[n][SAMPLE_BITS-2];
                shift_d[n]  = shift_src[n] << 2;
            end
            frame_clk_d = (slot_d < HALF_SLOT);
            data_clk_d  = !data_clk_q;
        end
    end

    // Single-entry holding register; a load and an accept may share one cycle.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        if (load_now) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            for (int n = 0; n < 4; n++) begin
                hold_d[n] = s00_axis.tdata[16*n +: SAMPLE_BITS];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            hold_full_q <= 1'b0;
            lane_a_q    <= '0;
            lane_b_q    <= '0;
            frame_clk_q <= 1'b0;
            data_clk_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            hold_full_q <= hold_full_d;
            lane_a_q    <= lane_a_d;
            lane_b_q    <= lane_b_d;
            frame_clk_q <= frame_clk_d;
            data_clk_q  <= data_clk_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: sample payloads are not reset; hold_full_q and the load path decide when they are seen.
    always_ff @(posedge s00_axis_aclk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

    assign FRAME_CLK   = frame_clk_q;
    assign DATA_CLK    = data_clk_q;
    assign CH_1_A      = lane_a_q[0];
    assign CH_1_B      = lane_b_q[0];
    assign CH_2_A      = lane_a_q[1];
    assign CH_2_B      = lane_b_q[1];
    assign CH_3_A      = lane_a_q[2];
    assign CH_3_B      = lane_b_q[2];
    assign CH_4_A      = lane_a_q[3];
    assign CH_4_B      = lane_b_q[3];
    assign underrun    = underrun_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_quad_adc_serializer_emu.sv
// Bench for quad_adc_serializer_emu: a cycle table for the streaming path, then hand
// sequences for drain, re-enable without gap, frame counter wrap and mid-frame reset.
module tb_quad_adc_serializer_emu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        fclk, dclk, und;
    logic        c1a, c1b, c2a, c2b, c3a, c3b, c4a, c4b;
    logic [15:0] fcnt;

    always #5 clk = ~clk;

    quad_adc_serializer_emu_if #(.DATA_W(64)) axis ();

    quad_adc_serializer_emu dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .enable          (en),
        .s00_axis        (axis),
        .FRAME_CLK       (fclk),
        .DATA_CLK        (dclk),
        .CH_1_A          (c1a),
        .CH_1_B          (c1b),
        .CH_2_A          (c2a),
        .CH_2_B          (c2b),
        .CH_3_A          (c3a),
        .CH_3_B          (c3b),
        .CH_4_A          (c4a),
        .CH_4_B          (c4b),
        .underrun        (und),
        .frame_count     (fcnt)
    );

    // Samples as {ch4, ch3, ch2, ch1}; S3 carries junk in the ignored top bits.
    localparam logic [63:0] S1 = {16'h00D1, 16'h00C1, 16'h00B1, 16'h00A1};
    localparam logic [63:0] S2 = {16'h3FFF, 16'h0000, 16'h1555, 16'h2AAA};
    localparam logic [63:0] S3 = {16'hC000, 16'h1555, 16'h2AAA, 16'hFFFF};
    localparam logic [63:0] S4 = {16'h1000, 16'h0003, 16'h2000, 16'h0001};

    typedef struct {
        logic        en;
        logic        tv;
        logic [63:0] td;
        logic        rdy;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        fclk;
        logic        prod;
        logic [15:0] cnt;
        logic        und;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   step_no = 0;
    logic m_dclk = 1'b0;

    // Hand-derived lane bits per slot: {A[ch4:ch1], B[ch4:ch1]}; id 0 is the all-zero sample.
    function automatic logic [7:0] pat(input int id, input int slot);
        case (id)
            1: case (slot)
                   3:       return {4'b1111, 4'b1100};
                   4:       return {4'b0011, 4'b1010};
                   6:       return {4'b0000, 4'b1111};
                   default: return 8'h00;
               endcase
            2: return (slot <= 6) ? {4'b1001, 4'b1010} : 8'h00;
            3: return (slot <= 6) ? {4'b0011, 4'b0101} : 8'h00;
            4: case (slot)
                   0:       return {4'b0010, 4'b1000};
                   6:       return {4'b0100, 4'b0101};
                   default: return 8'h00;
               endcase
            default: return 8'h00;
        endcase
    endfunction

    // slot < 0 means the engine shows idle outputs after this cycle.
    function automatic vec_t mk(input logic en_v, input logic tv_v, input logic [63:0] td_v,
                                input logic rdy_v, input int id, input int slot,
                                input logic [15:0] cnt_v, input logic und_v);
        vec_t v;
        v.en   = en_v;
        v.tv   = tv_v;
        v.td   = td_v;
        v.rdy  = rdy_v;
        {v.a, v.b} = (slot >= 0) ? pat(id, slot) : 8'h00;
        v.fclk = (slot >= 0) && (slot < 4);
        v.prod = (slot >= 0);
        v.cnt  = cnt_v;
        v.und  = und_v;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        step_no++;
        en          = v.en;
        axis.tvalid = v.tv;
        axis.tdata  = v.td;
        axis.tlast  = v.tv;
        #1;
        check($sformatf("step%0d tready", step_no), 32'(axis.tready), 32'(v.rdy));
        @(posedge clk);
        #1;
        if (v.prod) m_dclk = ~m_dclk;
        check($sformatf("step%0d lanes", step_no),
              32'({c4a, c3a, c2a, c1a, c4b, c3b, c2b, c1b}), 32'({v.a, v.b}));
        check($sformatf("step%0d frame_clk", step_no), 32'(fclk), 32'(v.fclk));
        check($sformatf("step%0d data_clk", step_no), 32'(dclk), 32'(m_dclk));
        check($sformatf("step%0d frame_count", step_no), 32'(fcnt), 32'(v.cnt));
        check($sformatf("step%0d underrun", step_no), 32'(und), 32'(v.und));
    endtask

    task automatic hand(input logic en_v, input logic tv_v, input logic [63:0] td_v,
                        input logic rdy_v, input int id, input int slot,
                        input logic [15:0] cnt_v, input logic und_v);
        run_vec(mk(en_v, tv_v, td_v, rdy_v, id, slot, cnt_v, und_v));
    endtask

    initial begin
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        axis.tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset tready", 32'(axis.tready), 32'd0);
        check("reset outputs", 32'({fclk, dclk, und, c4a, c3a, c2a, c1a, c4b, c3b, c2b, c1b}), 32'd0);
        check("reset frame_count", 32'(fcnt), 32'd0);
        rst = 1'b0;

        // Streaming table: preload, first frame, back-to-back loads, underrun, late sample.
        vecs.push_back(mk(1'b0, 1'b1, S1, 1'b1, 0, -1, 16'd0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, '0, 1'b1, 1, 0, 16'd1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, S2, 1'b1, 1, 1, 16'd1, 1'b0));
        for (int s = 2; s < 8; s++) vecs.push_back(mk(1'b1, 1'b1, S3, 1'b0, 1, s, 16'd1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, S3, 1'b1, 2, 0, 16'd2, 1'b0));
        for (int s = 1; s < 8; s++) vecs.push_back(mk(1'b1, 1'b0, '0, 1'b0, 2, s, 16'd2, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, '0, 1'b1, 3, 0, 16'd3, 1'b0));
        for (int s = 1; s < 8; s++) vecs.push_back(mk(1'b1, 1'b0, '0, 1'b1, 3, s, 16'd3, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, '0, 1'b1, 0, 0, 16'd4, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, S4, 1'b1, 0, 1, 16'd4, 1'b1));
        for (int s = 2; s < 8; s++) vecs.push_back(mk(1'b1, 1'b0, '0, 1'b0, 0, s, 16'd4, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, '0, 1'b1, 4, 0, 16'd5, 1'b1));
        for (int s = 1; s < 8; s++) vecs.push_back(mk(1'b1, 1'b0, '0, 1'b1, 4, s, 16'd5, 1'b1));
        foreach (vecs[i]) run_vec(vecs[i]);

        // Drop enable while slot 3 is shown: frame finishes, then idle with DATA_CLK held.
        hand(1'b1, 1'b1, S1, 1'b1, 0, 0, 16'd6, 1'b1);
        for (int s = 1; s < 8; s++) hand(1'b1, 1'b0, '0, 1'b0, 0, s, 16'd6, 1'b1);
        hand(1'b1, 1'b0, '0, 1'b1, 1, 0, 16'd7, 1'b1);
        for (int s = 1; s < 4; s++) hand(1'b1, 1'b0, '0, 1'b1, 1, s, 16'd7, 1'b1);
        for (int s = 4; s < 8; s++) hand(1'b0, 1'b0, '0, 1'b1, 1, s, 16'd7, 1'b1);
        for (int i = 0; i < 3; i++) hand(1'b0, 1'b0, '0, 1'b1, 0, -1, 16'd7, 1'b1);
        hand(1'b0, 1'b1, S2, 1'b1, 0, -1, 16'd7, 1'b1);

        // Re-enable while slot 5 is shown during drain: next frame follows with no gap.
        hand(1'b1, 1'b0, '0, 1'b1, 2, 0, 16'd8, 1'b1);
        for (int s = 1; s < 4; s++) hand(1'b1, 1'b0, '0, 1'b1, 2, s, 16'd8, 1'b1);
        hand(1'b0, 1'b0, '0, 1'b1, 2, 4, 16'd8, 1'b1);
        hand(1'b0, 1'b0, '0, 1'b1, 2, 5, 16'd8, 1'b1);
        hand(1'b1, 1'b0, '0, 1'b1, 2, 6, 16'd8, 1'b1);
        hand(1'b1, 1'b0, '0, 1'b1, 2, 7, 16'd8, 1'b1);
        hand(1'b1, 1'b0, '0, 1'b1, 0, 0, 16'd9, 1'b1);

        // Counter wrap: 65536 real frames would be far too long, so preset the count register.
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        for (int s = 1; s < 8; s++) hand(1'b1, 1'b0, '0, 1'b1, 0, s, 16'hFFFF, 1'b1);
        hand(1'b1, 1'b0, '0, 1'b1, 0, 0, 16'h0000, 1'b1);

        // Reset while slot 4 is shown and the holding register is full.
        hand(1'b1, 1'b1, S3, 1'b1, 0, 1, 16'd0, 1'b1);
        for (int s = 2; s < 5; s++) hand(1'b1, 1'b0, '0, 1'b0, 0, s, 16'd0, 1'b1);
        rst         = 1'b1;
        en          = 1'b1;
        axis.tvalid = 1'b1;
        axis.tdata  = S4;
        #1;
        check("midreset tready", 32'(axis.tready), 32'd0);
        @(posedge clk);
        #1;
        m_dclk = 1'b0;
        check("midreset outputs", 32'({fclk, dclk, und, c4a, c3a, c2a, c1a, c4b, c3b, c2b, c1b}), 32'd0);
        check("midreset frame_count", 32'(fcnt), 32'd0);
        rst = 1'b0;
        hand(1'b0, 1'b0, '0, 1'b1, 0, -1, 16'd0, 1'b0);
        hand(1'b1, 1'b0, '0, 1'b1, 0, 0, 16'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
